pipe_ctrl: RTL and testbench

//   Central pipeline sequencer for the 5-stage core. Arbitrates per-stage stall requests into the
//   6-bit stall vector consumed by the pc/if_id/id_ex/ex_mem/mem_wb registers.

---
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall arbitration, multi-cycle EX timer,
// exception/ERET flush with redirect PC, and stall watchdog.
module pipe_ctrl #(
  parameter int MC_CNT_W   = 6,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_len,
  input  logic                except_i,
  input  logic [31:0]         except_vec_i,
  input  logic                eret_i,
  input  logic [31:0]         epc_i,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                mc_busy,
  output logic [MC_CNT_W-1:0] mc_cnt,
  output logic                mc_done,
  output logic                wdog_timeout
);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  localparam logic [MC_CNT_W-1:0] MC_ONE = MC_CNT_W'(1);
  localparam logic [MC_CNT_W-1:0] MC_TWO = MC_CNT_W'(2);
  localparam logic [WDOG_W-1:0]   LIMIT  = WDOG_W'(WDOG_LIMIT);

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         pc_q;
  logic [31:0]         pc_nxt;
  logic                flush_c;

  logic                busy_q;
  logic [MC_CNT_W-1:0] cnt_q;
  logic [MC_CNT_W-1:0] last_q;
  logic [MC_CNT_W-1:0] len_eff;
  logic                mc_accept;
  logic                done_c;
  logic                ex_any;

  logic [5:0]          stall_c;
  logic [WDOG_W-1:0]   wd_cnt;
  logic [WDOG_W-1:0]   wd_nxt;
  logic                wd_flag;

  // Flush FSM state and latched redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  // Flush FSM next state; exception beats ERET, both ignored in FLUSH.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    flush_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (except_i) begin
          state_nxt = FLUSH;
          pc_nxt    = except_vec_i;
        end else if (eret_i) begin
          state_nxt = FLUSH;
          pc_nxt    = epc_i;
        end
      end
      FLUSH: begin
        flush_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign len_eff   = (mc_len < MC_TWO) ? MC_TWO : mc_len;
  assign mc_accept = mc_start & ~busy_q & ~flush_c;
  assign done_c    = busy_q & (cnt_q == last_q) & ~flush_c;
  assign ex_any    = stallreq_ex | mc_accept | (busy_q & ~done_c);

  // Multi-cycle timer: counts elapsed cycles, aborted by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      last_q <= '0;
    end else if (flush_c) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (mc_accept) begin
      busy_q <= 1'b1;
      cnt_q  <= MC_ONE;
      last_q <= len_eff - MC_ONE;
    end else if (busy_q) begin
      if (done_c) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + MC_ONE;
      end
    end
  end

  // Stall arbitration: deepest requesting stage wins.
  always_comb begin
    stall_c = 6'b000000;
    priority case (1'b1)
      flush_c:      stall_c = 6'b000000;
      stallreq_mem: stall_c = 6'b011111;
      ex_any:       stall_c = 6'b001111;
      stallreq_id:  stall_c = 6'b000111;
      stallreq_if:  stall_c = 6'b000011;
      default:      stall_c = 6'b000000;
    endcase
  end

  // Watchdog next count: run while PC held, saturate at all-ones.
  always_comb begin
    wd_nxt = wd_cnt;
    if (flush_c || !stall_c[0]) begin
      wd_nxt = '0;
    end else if (!(&wd_cnt)) begin
      wd_nxt = wd_cnt + 1'b1;
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else begin
      wd_cnt  <= wd_nxt;
      wd_flag <= wd_flag | (wd_nxt == LIMIT);
    end
  end

  assign stall        = stall_c;
  assign flush        = flush_c;
  assign new_pc       = flush_c ? pc_q : 32'h0;
  assign mc_busy      = busy_q;
  assign mc_cnt       = cnt_q;
  assign mc_done      = done_c;
  assign wdog_timeout = wd_flag;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: priority table,
// multi-cycle, flush, watchdog and async reset sequences.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [3:0]  req;
    logic        start;
    logic [5:0]  len;
    logic        exc;
    logic        eret;
    logic [31:0] vec;
    logic [31:0] epc;
  } in_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic [5:0]  cnt;
    logic        done;
    logic        wd;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if, stallreq_id;
  logic        stallreq_ex, stallreq_mem;
  logic        mc_start;
  logic [5:0]  mc_len;
  logic        except_i, eret_i;
  logic [31:0] except_vec_i, epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic [5:0]  mc_cnt;
  logic        mc_done;
  logic        wdog_timeout;

  int   errs   = 0;
  int   checks = 0;
  out_t sb[$];
  vec_t tbl[9];

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .mc_start(mc_start), .mc_len(mc_len),
    .except_i(except_i),
    .except_vec_i(except_vec_i),
    .eret_i(eret_i), .epc_i(epc_i),
    .stall(stall), .flush(flush),
    .new_pc(new_pc), .mc_busy(mc_busy),
    .mc_cnt(mc_cnt), .mc_done(mc_done),
    .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  function automatic in_t mi(
    logic [3:0] req, logic st, logic [5:0] len,
    logic exc, logic er,
    logic [31:0] vec, logic [31:0] epc);
    mi = '{req, st, len, exc, er, vec, epc};
  endfunction

  function automatic out_t mo(
    logic [5:0] s, logic f, logic [31:0] pc,
    logic b, logic [5:0] c, logic d, logic w);
    mo = '{s, f, pc, b, c, d, w};
  endfunction

  task automatic apply(input in_t i);
    stallreq_if  = i.req[0];
    stallreq_id  = i.req[1];
    stallreq_ex  = i.req[2];
    stallreq_mem = i.req[3];
    mc_start     = i.start;
    mc_len       = i.len;
    except_i     = i.exc;
    eret_i       = i.eret;
    except_vec_i = i.vec;
    epc_i        = i.epc;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  task automatic pop_cmp(input bit cpc);
    out_t x;
    x = sb.pop_front();
    chk("stall", 32'(stall), 32'(x.stall));
    chk("flush", 32'(flush), 32'(x.flush));
    if (cpc) chk("new_pc", new_pc, x.pc);
    chk("mc_busy", 32'(mc_busy), 32'(x.busy));
    chk("mc_cnt", 32'(mc_cnt), 32'(x.cnt));
    chk("mc_done", 32'(mc_done), 32'(x.done));
    chk("wdog", 32'(wdog_timeout), 32'(x.wd));
  endtask

  task automatic cyc(input in_t i, input out_t e);
    @(posedge clk);
    #1;
    apply(i);
    sb.push_back(e);
    @(negedge clk);
    pop_cmp(e.flush);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(mi(0, 0, 0, 0, 0, 0, 0));
    #1;
    sb.push_back(mo(0, 0, 0, 0, 0, 0, 0));
    pop_cmp(1'b1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  in_t  zi;
  in_t  ci;
  out_t ce;

  initial begin
    zi = mi(0, 0, 0, 0, 0, 0, 0);
    apply(zi);
    tbl[0] = '{mi(4'b0000, 0, 0, 0, 0, 0, 0), mo(6'b000000, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{mi(4'b0010, 0, 0, 0, 0, 0, 0), mo(6'b000111, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{mi(4'b1010, 0, 0, 0, 0, 0, 0), mo(6'b011111, 0, 0, 0, 0, 0, 0)};
    tbl[3] = '{mi(4'b0001, 0, 0, 0, 0, 0, 0), mo(6'b000011, 0, 0, 0, 0, 0, 0)};
    tbl[4] = '{mi(4'b0100, 0, 0, 0, 0, 0, 0), mo(6'b001111, 0, 0, 0, 0, 0, 0)};
    tbl[5] = '{mi(4'b0011, 0, 0, 0, 0, 0, 0), mo(6'b000111, 0, 0, 0, 0, 0, 0)};
    tbl[6] = '{mi(4'b0110, 0, 0, 0, 0, 0, 0), mo(6'b001111, 0, 0, 0, 0, 0, 0)};
    tbl[7] = '{mi(4'b1001, 0, 0, 0, 0, 0, 0), mo(6'b011111, 0, 0, 0, 0, 0, 0)};
    tbl[8] = '{mi(4'b1111, 0, 0, 0, 0, 0, 0), mo(6'b011111, 0, 0, 0, 0, 0, 0)};

    // reset state
    #12;
    sb.push_back(mo(0, 0, 0, 0, 0, 0, 0));
    pop_cmp(1'b1);
    @(negedge clk);
    rst = 1'b1;

    // stall priority table
    for (int k = 0; k < 9; k++) cyc(tbl[k].i, tbl[k].e);
    cyc(zi, mo(0, 0, 0, 0, 0, 0, 0));

    // multi-cycle len 5, second start at t+2 ignored
    for (int k = 0; k < 7; k++) begin
      ci = mi(0, (k == 0 || k == 2), 6'd5, 0, 0, 0, 0);
      ce = mo((k <= 3) ? 6'b001111 : 6'b0, 0, 0,
              (k >= 1 && k <= 4),
              (k >= 1 && k <= 4) ? 6'(k) : 6'd0,
              (k == 4), 0);
      cyc(ci, ce);
    end

    // mc_len 1 and 0 behave as length 2
    for (int n = 0; n < 2; n++) begin
      cyc(mi(0, 1, 6'(1 - n), 0, 0, 0, 0),
          mo(6'b001111, 0, 0, 0, 0, 0, 0));
      cyc(zi, mo(0, 0, 0, 1, 1, 1, 0));
      cyc(zi, mo(0, 0, 0, 0, 0, 0, 0));
    end

    // exception flush; eret during FLUSH ignored
    cyc(mi(0, 0, 0, 1, 0, 32'h20, 0),
        mo(0, 0, 0, 0, 0, 0, 0));
    cyc(mi(4'b1000, 0, 0, 0, 1, 0, 32'h100),
        mo(0, 1, 32'h20, 0, 0, 0, 0));
    cyc(zi, mo(0, 0, 0, 0, 0, 0, 0));
    cyc(zi, mo(0, 0, 0, 0, 0, 0, 0));

    // eret alone redirects to epc
    cyc(mi(0, 0, 0, 0, 1, 0, 32'h300),
        mo(0, 0, 0, 0, 0, 0, 0));
    cyc(zi, mo(0, 1, 32'h300, 0, 0, 0, 0));

    // except and eret together: exception wins
    cyc(mi(0, 0, 0, 1, 1, 32'h20, 32'h100),
        mo(0, 0, 0, 0, 0, 0, 0));
    cyc(zi, mo(0, 1, 32'h20, 0, 0, 0, 0));
    cyc(zi, mo(0, 0, 0, 0, 0, 0, 0));

    // exception at mc cycle t+2 aborts op
    for (int k = 0; k < 6; k++) begin
      ci = mi(0, (k == 0), 6'd5, (k == 2), 0, 32'h40, 0);
      ce = mo((k <= 2) ? 6'b001111 : 6'b0, (k == 3),
              (k == 3) ? 32'h40 : 32'h0,
              (k >= 1 && k <= 3),
              (k >= 1 && k <= 3) ? 6'(k) : 6'd0,
              0, 0);
      cyc(ci, ce);
    end

    // watchdog: 1000 stalled cycles trip sticky flag
    do_reset();
    for (int k = 1; k <= 1003; k++) begin
      cyc(mi(4'b0001, 0, 0, 0, 0, 0, 0),
          mo(6'b000011, 0, 0, 0, 0, 0, (k > 1000)));
    end
    for (int k = 0; k < 3; k++) cyc(zi, mo(0, 0, 0, 0, 0, 0, 1));

    // async reset mid multi-cycle op
    do_reset();
    cyc(mi(0, 1, 6'd5, 0, 0, 0, 0),
        mo(6'b001111, 0, 0, 0, 0, 0, 0));
    cyc(zi, mo(6'b001111, 0, 0, 1, 1, 0, 0));
    #1;
    rst = 1'b0;
    #1;
    sb.push_back(mo(0, 0, 0, 0, 0, 0, 0));
    pop_cmp(1'b1);
    @(negedge clk);
    rst = 1'b1;

    // async reset mid FLUSH
    cyc(mi(0, 0, 0, 1, 0, 32'h80, 0),
        mo(0, 0, 0, 0, 0, 0, 0));
    cyc(zi, mo(0, 1, 32'h80, 0, 0, 0, 0));
    #1;
    rst = 1'b0;
    #1;
    sb.push_back(mo(0, 0, 0, 0, 0, 0, 0));
    pop_cmp(1'b1);
    @(negedge clk);
    rst = 1'b1;
    cyc(zi, mo(0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
